// File: rtl/cpu_pc_stack_pkg.sv
// rtl/cpu_pc_stack_pkg.sv - shared subcycle encoding and widths for the PC/stack block
package cpu_pc_stack_pkg;

    localparam int PC_W  = 12;
    localparam int PTR_W = 2;
    localparam logic [PTR_W-1:0] DEPTH_MAX = 2'd3;

    typedef enum logic [2:0] {
        SUBCYCLE_A1 = 3'd0,
        SUBCYCLE_A2 = 3'd1,
        SUBCYCLE_A3 = 3'd2,
        SUBCYCLE_M1 = 3'd3,
        SUBCYCLE_M2 = 3'd4,
        SUBCYCLE_X1 = 3'd5,
        SUBCYCLE_X2 = 3'd6,
        SUBCYCLE_X3 = 3'd7
    } subcycle_e;

    // Address nibble placed on the bus in a given subcycle; zero outside A1..A3.
    function automatic logic [3:0] addr_nibble(input logic [PC_W-1:0] pc, input subcycle_e cyc);
        logic [3:0] nib;
        nib = 4'h0;
        case (cyc)
            SUBCYCLE_A1: nib = pc[3:0];
            SUBCYCLE_A2: nib = pc[7:4];
            SUBCYCLE_A3: nib = pc[11:8];
            default:     nib = 4'h0;
        endcase
        return nib;
    endfunction

endpackage

// File: rtl/cpu_pc_stack_if.sv
// rtl/cpu_pc_stack_if.sv - subcycle/flow-control inputs and fetch-address outputs of the PC stack
interface cpu_pc_stack_if;
    logic [2:0]  cycle;
    logic        jump_en;
    logic        call_en;
    logic        ret_en;
    logic [11:0] jump_addr;
    logic [3:0]  addr_out;
    logic        addr_oe;
    logic [11:0] pc;
    logic [1:0]  stack_depth;
    logic        stack_overflow;
    logic        stack_underflow;

    modport master (
        output cycle, jump_en, call_en, ret_en, jump_addr,
        input  addr_out, addr_oe, pc, stack_depth, stack_overflow, stack_underflow
    );

    modport slave (
        input  cycle, jump_en, call_en, ret_en, jump_addr,
        output addr_out, addr_oe, pc, stack_depth, stack_overflow, stack_underflow
    );
endinterface

// File: rtl/cpu_addr_file.sv
// rtl/cpu_addr_file.sv - 4x12 address register file, one write port and one read port
module cpu_addr_file #(
    parameter logic [11:0] RESET_PC = 12'h000
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        we_i,
    input  logic [1:0]  waddr_i,
    input  logic [11:0] wdata_i,
    input  logic [1:0]  raddr_i,
    output logic [11:0] rdata_o
);

    logic [11:0] regs_q [4];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            regs_q[0] <= RESET_PC;
            regs_q[1] <= 12'h000;
            regs_q[2] <= 12'h000;
            regs_q[3] <= 12'h000;
        end else if (we_i) begin
            regs_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = regs_q[raddr_i];

endmodule

// File: rtl/cpu_pc_stack.sv
// rtl/cpu_pc_stack.sv - program counter with 3-level return stack, nibble-serial fetch address
module cpu_pc_stack
    import cpu_pc_stack_pkg::*;
#(
    parameter logic [11:0] RESET_PC = 12'h000
) (
    input  logic          clock,
    input  logic          reset_n,
    cpu_pc_stack_if.slave bus
);

    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic [PTR_W-1:0] depth_q, depth_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;
    logic             started_q, started_d;

    logic             wr_en;
    logic [PTR_W-1:0] wr_addr;
    logic [PC_W-1:0]  wr_data;
    logic [PC_W-1:0]  pc_cur;
    subcycle_e        cyc;

    assign cyc = subcycle_e'(bus.cycle);

    cpu_addr_file #(.RESET_PC(RESET_PC)) u_addr_file (
        .clock   (clock),
        .reset_n (reset_n),
        .we_i    (wr_en),
        .waddr_i (wr_addr),
        .wdata_i (wr_data),
        .raddr_i (ptr_q),
        .rdata_o (pc_cur)
    );

    // After reset nothing advances until cpu_control reports an A1, so a
    // reset released mid-instruction never sees a stray increment or pop.
    always_comb begin
        ptr_d     = ptr_q;
        depth_d   = depth_q;
        ovf_d     = ovf_q;
        unf_d     = unf_q;
        started_d = started_q | (cyc == SUBCYCLE_A1);
        wr_en     = 1'b0;
        wr_addr   = ptr_q;
        wr_data   = pc_cur;
        if (started_q) begin
            if (cyc == SUBCYCLE_A3) begin
                wr_en   = 1'b1;
                wr_data = pc_cur + 12'd1;
            end else if (cyc == SUBCYCLE_X3) begin
                if (bus.call_en) begin
                    // Caller's incremented PC stays in its slot as the return address.
                    wr_en   = 1'b1;
                    wr_addr = ptr_q + 2'd1;
                    wr_data = bus.jump_addr;
                    ptr_d   = ptr_q + 2'd1;
                    if (depth_q == DEPTH_MAX) ovf_d = 1'b1;
                    else                      depth_d = depth_q + 2'd1;
                end else if (bus.jump_en) begin
                    wr_en   = 1'b1;
                    wr_data = bus.jump_addr;
                end else if (bus.ret_en) begin
                    ptr_d = ptr_q - 2'd1;
                    if (depth_q == 2'd0) unf_d = 1'b1;
                    else                 depth_d = depth_q - 2'd1;
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ptr_q     <= '0;
            depth_q   <= '0;
            ovf_q     <= 1'b0;
            unf_q     <= 1'b0;
            started_q <= 1'b0;
        end else begin
            ptr_q     <= ptr_d;
            depth_q   <= depth_d;
            ovf_q     <= ovf_d;
            unf_q     <= unf_d;
            started_q <= started_d;
        end
    end

    assign bus.addr_out        = addr_nibble(pc_cur, cyc);
    assign bus.addr_oe         = (cyc == SUBCYCLE_A1) || (cyc == SUBCYCLE_A2) || (cyc == SUBCYCLE_A3);
    assign bus.pc              = pc_cur;
    assign bus.stack_depth     = depth_q;
    assign bus.stack_overflow  = ovf_q;
    assign bus.stack_underflow = unf_q;

endmodule

// File: tb/tb_cpu_pc_stack.sv
// tb/tb_cpu_pc_stack.sv - scoreboard bench for cpu_pc_stack fetch nibbles and stack state
module tb_cpu_pc_stack;

    logic clk;
    logic rst_n;

    cpu_pc_stack_if bus ();

    cpu_pc_stack #(.RESET_PC(12'h000)) dut (
        .clock   (clk),
        .reset_n (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [3:0] exp_q [$];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every driven address nibble must match the next expected one.
    always @(negedge clk) begin
        if (rst_n && bus.addr_oe) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_nibble: got %0h expected none", bus.addr_out);
            end else begin
                check("addr_nibble", int'(bus.addr_out), int'(exp_q.pop_front()));
            end
        end
    end

    task automatic push_pc(input logic [11:0] p);
        exp_q.push_back(p[3:0]);
        exp_q.push_back(p[7:4]);
        exp_q.push_back(p[11:8]);
    endtask

    // One 8-subcycle instruction fetched from exp_pc; flow inputs asserted in subcycle fc.
    task automatic instr(input logic [11:0] exp_pc, input int fc,
                         input logic j, input logic c, input logic r, input logic [11:0] a);
        push_pc(exp_pc);
        for (int k = 0; k < 8; k++) begin
            bus.cycle     = 3'(k);
            bus.jump_en   = (k == fc) ? j : 1'b0;
            bus.call_en   = (k == fc) ? c : 1'b0;
            bus.ret_en    = (k == fc) ? r : 1'b0;
            bus.jump_addr = a;
            @(posedge clk);
            #1;
        end
        bus.jump_en = 1'b0;
        bus.call_en = 1'b0;
        bus.ret_en  = 1'b0;
    endtask

    task automatic plain(input logic [11:0] exp_pc);
        instr(exp_pc, 7, 1'b0, 1'b0, 1'b0, 12'h000);
    endtask

    initial begin
        rst_n         = 1'b0;
        bus.cycle     = 3'd0;
        bus.jump_en   = 1'b0;
        bus.call_en   = 1'b0;
        bus.ret_en    = 1'b0;
        bus.jump_addr = 12'h000;
        #3;
        check("reset_pc", int'(bus.pc), 12'h000);
        check("reset_addr_out", int'(bus.addr_out), 0);
        check("reset_addr_oe", int'(bus.addr_oe), 1);
        check("reset_depth", int'(bus.stack_depth), 0);
        check("reset_ovf", int'(bus.stack_overflow), 0);
        check("reset_unf", int'(bus.stack_underflow), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        plain(12'h000);
        plain(12'h001);
        check("pc_after_two", int'(bus.pc), 12'h002);

        instr(12'h002, 7, 1'b1, 1'b0, 1'b0, 12'hFFF);
        plain(12'hFFF);
        check("pc_wrap", int'(bus.pc), 12'h000);
        plain(12'h000);

        instr(12'h001, 7, 1'b1, 1'b0, 1'b0, 12'h122);
        instr(12'h122, 7, 1'b0, 1'b1, 1'b0, 12'h456);
        check("call_depth", int'(bus.stack_depth), 1);
        check("call_pc", int'(bus.pc), 12'h456);
        instr(12'h456, 7, 1'b0, 1'b0, 1'b1, 12'h000);
        check("ret_depth", int'(bus.stack_depth), 0);
        check("ret_pc", int'(bus.pc), 12'h123);
        plain(12'h123);

        instr(12'h124, 7, 1'b0, 1'b1, 1'b0, 12'h200);
        instr(12'h200, 7, 1'b0, 1'b1, 1'b0, 12'h300);
        instr(12'h300, 7, 1'b0, 1'b1, 1'b0, 12'h400);
        check("depth3_no_ovf", int'(bus.stack_overflow), 0);
        instr(12'h400, 7, 1'b0, 1'b1, 1'b0, 12'h500);
        check("ovf_depth", int'(bus.stack_depth), 3);
        check("ovf_flag", int'(bus.stack_overflow), 1);
        instr(12'h500, 7, 1'b0, 1'b0, 1'b1, 12'h000);
        check("pop1_depth", int'(bus.stack_depth), 2);
        instr(12'h401, 7, 1'b0, 1'b0, 1'b1, 12'h000);
        instr(12'h301, 7, 1'b0, 1'b0, 1'b1, 12'h000);
        check("pop3_depth", int'(bus.stack_depth), 0);
        check("pop3_not_caller", int'(bus.pc), 12'h201);
        plain(12'h201);

        instr(12'h202, 5, 1'b1, 1'b0, 1'b0, 12'h7AB);
        check("jump_x1_ignored", int'(bus.pc), 12'h203);
        instr(12'h203, 7, 1'b1, 1'b0, 1'b1, 12'h7AB);
        check("jump_over_ret_pc", int'(bus.pc), 12'h7AB);
        check("jump_over_ret_depth", int'(bus.stack_depth), 0);
        check("jump_over_ret_unf", int'(bus.stack_underflow), 0);
        plain(12'h7AB);

        instr(12'h7AC, 7, 1'b0, 1'b0, 1'b1, 12'h000);
        check("unf_flag", int'(bus.stack_underflow), 1);
        check("unf_depth", int'(bus.stack_depth), 0);
        plain(12'h501);
        check("unf_sticky", int'(bus.stack_underflow), 1);
        check("ovf_sticky", int'(bus.stack_overflow), 1);

        // Partial instruction, reset pulse in M2, then cpu_control resumes at A2.
        push_pc(12'h502);
        for (int k = 0; k < 4; k++) begin
            bus.cycle = 3'(k);
            @(posedge clk);
            #1;
        end
        bus.cycle = 3'd4;
        rst_n     = 1'b0;
        #2;
        check("pulse_pc", int'(bus.pc), 12'h000);
        check("pulse_ovf", int'(bus.stack_overflow), 0);
        check("pulse_unf", int'(bus.stack_underflow), 0);
        check("pulse_depth", int'(bus.stack_depth), 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        exp_q.push_back(4'h0);
        exp_q.push_back(4'h0);
        for (int k = 1; k < 8; k++) begin
            bus.cycle = 3'(k);
            bus.ret_en = (k == 7);
            @(posedge clk);
            #1;
        end
        bus.ret_en = 1'b0;
        check("restart_pc", int'(bus.pc), 12'h000);
        check("restart_depth", int'(bus.stack_depth), 0);
        plain(12'h000);
        check("restart_inc", int'(bus.pc), 12'h001);

        check("queue_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cpu_pc_stack.md
# cpu_pc_stack

- Program counter and 3-level subroutine address stack for the 4-bit CPU.
- Sits directly upstream of cpu_control on the instruction-fetch path.
- Drives the 12-bit fetch address onto the multiplexed 4-bit bus, one nibble per subcycle A1–A3, ahead of the opcode nibbles that cpu_control latches in M1/M2.
- Auto-increments once per instruction cycle and applies jump, call and return requests at instruction end.

## Interface
Parameters:
- RESET_PC, 12'h000, PC value loaded on reset.

Ports:
- clock  in  1  system clock.
- reset_n  in  1  reset, asynchronous, active-low; single clock domain.
- cycle  in  3  current subcycle from cpu_control (0=A1 … 7=X3).
- jump_en  in  1  load PC with jump_addr at end of X3.
- call_en  in  1  push the current (already-incremented) PC, then load jump_addr, at end of X3.
- ret_en  in  1  pop; resume at the saved return address, at end of X3.
- jump_addr  in  12  target address for jump/call.
- addr_out  out  4  address nibble for the bus.
- addr_oe  out  1  bus drive enable; high while cycle ∈ {0,1,2}.
- pc  out  12  active program counter (debug/visibility).
- stack_depth  out  2  number of live return addresses, 0..3.
- stack_overflow  out  1  sticky; set on a push when depth==3.
- stack_underflow  out  1  sticky; set on a pop when depth==0.

## Operation
- Storage: four 12-bit address registers plus a 2-bit pointer `ptr`. The active PC is `regs[ptr]`.
- Address drive:
  - cycle 0 → `addr_out = pc[3:0]`
  - cycle 1 → `addr_out = pc[7:4]`
  - cycle 2 → `addr_out = pc[11:8]`
  - cycles 3–7 → `addr_out = 0`, `addr_oe = 0`.
- Increment: `regs[ptr] <= regs[ptr] + 1` at the clock edge where cycle==2. Wraps mod 4096 (12'hFFF → 12'h000).
- Flow control: sampled only at the edge where cycle==7; ignored in all other subcycles. Priority when several are asserted: call_en > jump_en > ret_en.
  - Jump: `regs[ptr] <= jump_addr`.
  - Call: `regs[ptr+1] <= jump_addr`; `ptr <= ptr+1`. The caller's incremented PC stays in place as the return address. Depth increments, saturating at 3.
    - Push at depth 3: pointer wraps mod 4, the oldest return address is overwritten, depth stays 3, stack_overflow is set.
  - Return: `ptr <= ptr-1`. Depth decrements.
    - Pop at depth 0: pointer still wraps mod 4, depth stays 0, stack_underflow is set. Execution resumes at whatever is stored in the wrapped slot.
- Flags: stack_overflow and stack_underflow clear only on reset.
- Reset:
  - `ptr = 0`, `regs[0] = RESET_PC`, other regs = 0.
  - depth = 0, both flags = 0.
  - `addr_out = RESET_PC[3:0]` if cycle==0, else 0.

## Timing
- All state updates happen on rising clock edges; reset_n acts asynchronously.
- addr_out, addr_oe and pc are combinational from `cycle` and the register state. They are valid within the same clock period as the cycle value; no added latency.
- The PC value driven in A1–A3 of instruction N+1 reflects:
  - the increment applied at end of A3 of instruction N, and
  - any flow change applied at end of X3 of instruction N.
- Two-word instructions: the second word is fetched as a normal instruction cycle, with its own increment. The caller asserts flow control in the X3 of the second word.
- Reset_n deasserted mid-instruction: the block restarts from RESET_PC at the next A1 reported by `cycle`. No partial push or pop is retained.

## Structure
- Subcycle names go in a shared header `cycle.vh`, alongside datapath.vh: SUBCYCLE_A1=0, A2=1, A3=2, M1=3, M2=4, X1=5, X2=6, X3=7. cpu_control and this block both include it.
- One natural sub-module: `cpu_addr_file`, the 4×12 register file.
  - Ports: one write port (address, data, enable) and one read port indexed by `ptr`.
- Pointer, depth and flag logic stays in the top module.

## Test plan
- Reset, then run two instruction cycles with no flow control → addr_out is 0,0,0 in A1–A3 of the first instruction, then 1,0,0 in the second; pc==12'h002 after the second A3.
- PC at 12'hFFF, run one increment → pc==12'h000, addr_out in the next A1–A3 is 0,0,0.
- With pc==12'h123 after A3, assert call_en with jump_addr=12'h456 in X3 → next fetch nibbles 6,5,4; stack_depth==1. Then ret_en at the callee's X3 → next fetch nibbles 3,2,1 (resumes at 12'h123); stack_depth==0.
- Four nested calls → stack_depth stays 3, stack_overflow==1. Then three returns → the third lands on the overwritten slot, not the original caller; stack_depth==0.
- Assert jump_en in cycle 5 → no effect. Assert jump_en and ret_en together in X3 → jump wins and stack_depth is unchanged.
- Assert ret_en at depth 0 → stack_underflow==1 and stays set until reset_n is pulsed low mid-instruction. After the pulse, flags==0 and the next A1 drives RESET_PC[3:0].
